// File: rtl/value_to_char_arr.sv
// value_to_char_arr: sequential double-dabble conversion of an unsigned value
// into packed decimal character codes, committed on a vsync rising edge
// (or immediately) so the overlay never shows a half-updated number.
module value_to_char_arr #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DIGITS     = 5,
    parameter logic [7:0]  DIGIT_BASE = 8'h30,
    parameter logic [7:0]  BLANK_CODE = 8'h20,
    parameter bit          LZ_BLANK   = 1'b1,
    parameter bit          VS_SYNC    = 1'b1
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  i_vs,
    input  logic [DATA_W-1:0]     i_value,
    input  logic                  i_valid,
    output logic [DIGITS*8-1:0]   o_char_arr,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CHR_W = 8 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHIFT   = 2'd1;
    localparam logic [1:0] S_FORMAT  = 2'd2;
    localparam logic [1:0] S_WAIT_VS = 2'd3;

    // 10^n evaluated at elaboration time
    function automatic logic [63:0] pow10(input int unsigned n);
        pow10 = 64'd1;
        for (int unsigned i = 0; i < n; i++) pow10 = pow10 * 64'd10;
    endfunction

    // Largest value representable in DIGITS decimal digits
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        add3 = b;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (b[4*i +: 4] >= 4'd5) add3[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
    endfunction

    // BCD nibbles to character codes with optional leading-zero blanking
    function automatic logic [CHR_W-1:0] fmt_chars(input logic [BCD_W-1:0] b);
        logic       lead;
        logic [3:0] nib;
        fmt_chars = '0;
        lead      = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            nib = b[4*i +: 4];
            if (nib != 4'd0) lead = 1'b0;
            if (LZ_BLANK && lead && (i != 0)) fmt_chars[8*i +: 8] = BLANK_CODE;
            else                              fmt_chars[8*i +: 8] = DIGIT_BASE + {4'd0, nib};
        end
    endfunction

    // A zero value formats to exactly the reset display pattern
    localparam logic [CHR_W-1:0] RST_CHARS = fmt_chars('0);

    logic [1:0]        state, state_nxt;
    logic [DATA_W-1:0] bin, bin_nxt;
    logic [BCD_W-1:0]  bcd, bcd_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CHR_W-1:0]  pend, pend_nxt;
    logic [CHR_W-1:0]  chars_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              vs_d;
    logic              sat_c;

    assign sat_c = 64'(i_value) > MAX_VAL;

    // State and datapath registers with synchronous reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= S_IDLE;
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            pend       <= RST_CHARS;
            o_char_arr <= RST_CHARS;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            vs_d       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bin        <= bin_nxt;
            bcd        <= bcd_nxt;
            cnt        <= cnt_nxt;
            pend       <= pend_nxt;
            o_char_arr <= chars_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
            vs_d       <= i_vs;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        bin_nxt   = bin;
        bcd_nxt   = bcd;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        chars_nxt = o_char_arr;
        busy_nxt  = o_busy;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    bin_nxt   = sat_c ? DATA_W'(MAX_VAL) : i_value;
                    bcd_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_nxt, bin_nxt} = {add3(bcd), bin} << 1;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W - 1)) state_nxt = S_FORMAT;
            end
            S_FORMAT: begin
                pend_nxt = fmt_chars(bcd);
                if (VS_SYNC) begin
                    state_nxt = S_WAIT_VS;
                end else begin
                    chars_nxt = fmt_chars(bcd);
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_VS: begin
                if (i_vs && !vs_d) begin
                    chars_nxt = pend;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
